// File: rtl/rx_bit_sampler_pkg.sv
// Shared UART RX definitions: widths, legal oversampling ratios and the vote helper.
package rx_bit_sampler_pkg;

  localparam int unsigned PRESCALE_W = 6;
  localparam int unsigned BIT_CNT_W  = 4;

  typedef logic [PRESCALE_W-1:0] prescale_t;
  typedef logic [BIT_CNT_W-1:0]  bit_cnt_t;

  localparam prescale_t PRESCALE_X8  = prescale_t'(8);
  localparam prescale_t PRESCALE_X16 = prescale_t'(16);
  localparam prescale_t PRESCALE_X32 = prescale_t'(32);

  // 2-of-3 majority used to reject a single-sample glitch around mid-bit.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_bit_sampler_if.sv
// Bundle between the RX FSM (master) and the bit sampler (slave).
interface rx_bit_sampler_if import rx_bit_sampler_pkg::*; ();

  logic      smp_en;
  logic      rx_in;
  prescale_t prescale;
  logic      sampled_bit;
  logic      sample_valid;
  prescale_t edge_cnt;
  bit_cnt_t  bit_cnt;

  modport master (
    output smp_en, rx_in, prescale,
    input  sampled_bit, sample_valid, edge_cnt, bit_cnt
  );

  modport slave (
    input  smp_en, rx_in, prescale,
    output sampled_bit, sample_valid, edge_cnt, bit_cnt
  );

endinterface

// File: rtl/rx_bit_sampler_edge_bit_counter.sv
// Edge (position within bit) and bit (position within frame) counters.
module rx_bit_sampler_edge_bit_counter import rx_bit_sampler_pkg::*; (
  input  logic      clk,
  input  logic      rst,
  input  logic      smp_en_i,
  input  prescale_t prescale_i,
  output prescale_t edge_cnt_o,
  output bit_cnt_t  bit_cnt_o
);

  prescale_t edge_cnt_d, edge_cnt_q;
  bit_cnt_t  bit_cnt_d, bit_cnt_q;
  logic      last_edge;

  // >= rather than == keeps the counter bounded even if prescale is illegal.
  assign last_edge = (edge_cnt_q >= (prescale_i - prescale_t'(1)));

  // Compare-and-wrap edge counter; bit counter advances on the same edge it wraps.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (!smp_en_i) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (last_edge) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + bit_cnt_t'(1);
    end else begin
      edge_cnt_d = edge_cnt_q + prescale_t'(1);
    end
  end

  // Counter state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt_o = edge_cnt_q;
  assign bit_cnt_o  = bit_cnt_q;

endmodule

// File: rtl/rx_bit_sampler.sv
// UART RX bit sampler: three mid-bit samples, majority vote and a one-cycle valid strobe.
module rx_bit_sampler import rx_bit_sampler_pkg::*; (
  input logic             clk,
  input logic             rst,
  rx_bit_sampler_if.slave bus
);

  prescale_t edge_cnt;
  bit_cnt_t  bit_cnt;
  prescale_t mid;
  logic [2:0] smp_d, smp_q;
  logic       sampled_bit_d, sampled_bit_q;
  logic       sample_valid_d, sample_valid_q;

  rx_bit_sampler_edge_bit_counter u_edge_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .smp_en_i   (bus.smp_en),
    .prescale_i (bus.prescale),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt)
  );

  assign mid = bus.prescale >> 1;

  // Capture at mid-2/mid-1/mid, vote one edge after the last capture.
  always_comb begin
    smp_d          = smp_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    if (!bus.smp_en) begin
      smp_d = '0;
    end else begin
      if (edge_cnt == (mid - prescale_t'(2))) smp_d[0] = bus.rx_in;
      if (edge_cnt == (mid - prescale_t'(1))) smp_d[1] = bus.rx_in;
      if (edge_cnt == mid)                    smp_d[2] = bus.rx_in;
      if (edge_cnt == (mid + prescale_t'(1))) begin
        sampled_bit_d  = majority3(smp_q[0], smp_q[1], smp_q[2]);
        sample_valid_d = 1'b1;
      end
    end
  end

  // Sample/vote registers; sampled_bit is the only one that survives smp_en=0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      smp_q          <= '0;
      sampled_bit_q  <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      smp_q          <= smp_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign bus.sampled_bit  = sampled_bit_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.edge_cnt     = edge_cnt;
  assign bus.bit_cnt      = bit_cnt;

endmodule
